// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM burst arbiter
//
// Purpose: arbiter FSM state type, requester port indices and bus widths.
// Ports:   none (package).

package sram_arb_pkg;

    // Raw state codes stay visible for legacy code that compares against constants.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ACTIVE  = ST_ACTIVE,
        RELEASE = ST_RELEASE
    } arb_state_t;

    // Requester assignment on the shared SRAM port.
    localparam int PORT_DISPLAY  = 0;
    localparam int PORT_PIXEL_WR = 1;
    localparam int PORT_TEXTURE  = 2;
    localparam int PORT_SPI      = 3;

    localparam int BURST_LEN_W = 8;
    localparam int WDATA_W     = 32;
    localparam int BEAT_W      = 16;

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - fixed-priority bit 0 plus round-robin winner select
//
// Purpose: pick one requester. Bit 0 always wins; otherwise the first
//          requesting index >= 1 at or after i_rr_ptr, wrapping N-1 -> 1.
// Ports:   i_req    request vector
//          i_rr_ptr round-robin start index (1..N-1)
//          o_grant  winning index
//          o_valid  a winner exists

module rr_priority_select
    import sram_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [IW-1:0] o_grant,
    output logic          o_valid
);

    // Size of the rotating group (ports 1..N-1); kept >= 1 so the modulo is legal for N=1.
    localparam int NR = (N > 1) ? N - 1 : 1;

    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        if (i_req[PORT_DISPLAY]) begin
            o_valid = 1'b1;
            o_grant = IW'(PORT_DISPLAY);
        end else begin
            // Candidate k is the k-th port after the pointer inside the 1..N-1 ring.
            for (int k = 0; k < N - 1; k++) begin
                if (!o_valid && i_req[IW'(((int'(i_rr_ptr) - 1 + k + NR) % NR) + 1)]) begin
                    o_valid = 1'b1;
                    o_grant = IW'(((int'(i_rr_ptr) - 1 + k + NR) % NR) + 1);
                end
            end
        end
    end

endmodule

// File: rtl/sram_burst_arbiter.sv
// rtl/sram_burst_arbiter.sv - non-preemptive arbiter sharing one SRAM controller port
//
// Purpose: latch one requester's transaction, forward it to the SRAM
//          controller, route ack/read data/burst beats back to that port,
//          then insert a one-cycle release bubble before the next grant.
// Ports:   clk_sram, rst_n_sram          clock, async active-low reset
//          p_req/p_we/p_addr/p_wdata/p_burst_len   per-port requests (flattened)
//          p_ack/p_ready/p_rdata/p_burst_rdata/p_burst_valid   per-port responses
//          m_req/m_we/m_addr/m_wdata/m_burst_len   to SRAM controller
//          m_rdata/m_burst_rdata/m_burst_valid/m_ack/m_ready   from SRAM controller

module sram_burst_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 24
) (
    input  logic                                clk_sram,
    input  logic                                rst_n_sram,
    input  logic [NUM_PORTS-1:0]                p_req,
    input  logic [NUM_PORTS-1:0]                p_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]         p_addr,
    input  logic [NUM_PORTS*WDATA_W-1:0]        p_wdata,
    input  logic [NUM_PORTS*BURST_LEN_W-1:0]    p_burst_len,
    output logic [NUM_PORTS-1:0]                p_ack,
    output logic [NUM_PORTS-1:0]                p_ready,
    output logic [WDATA_W-1:0]                  p_rdata,
    output logic [BEAT_W-1:0]                   p_burst_rdata,
    output logic [NUM_PORTS-1:0]                p_burst_valid,
    output logic                                m_req,
    output logic                                m_we,
    output logic [ADDR_W-1:0]                   m_addr,
    output logic [WDATA_W-1:0]                  m_wdata,
    output logic [BURST_LEN_W-1:0]              m_burst_len,
    input  logic [WDATA_W-1:0]                  m_rdata,
    input  logic [BEAT_W-1:0]                   m_burst_rdata,
    input  logic                                m_burst_valid,
    input  logic                                m_ack,
    input  logic                                m_ready
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t               r_state;
    logic [IW-1:0]            r_grant;
    logic [IW-1:0]            r_rr_ptr;
    logic [NUM_PORTS-1:0]     r_rel_mask;
    logic                     r_m_req;
    logic                     r_m_we;
    logic [ADDR_W-1:0]        r_m_addr;
    logic [WDATA_W-1:0]       r_m_wdata;
    logic [BURST_LEN_W-1:0]   r_m_burst_len;

    logic [NUM_PORTS-1:0]     w_eligible;
    logic [IW-1:0]            w_sel_grant;
    logic                     w_sel_valid;
    logic [NUM_PORTS-1:0]     w_grant_onehot;
    logic                     w_active;
    logic                     w_ack_fire;
    logic                     w_beat_fire;

    // The port just retired may still show req for one cycle; keep it out of arbitration.
    assign w_eligible = p_req & ~r_rel_mask;

    rr_priority_select #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_select (
        .i_req    (w_eligible),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_sel_grant),
        .o_valid  (w_sel_valid)
    );

    always_ff @(posedge clk_sram or negedge rst_n_sram) begin
        if (!rst_n_sram) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= IW'(1);
            r_rel_mask    <= '0;
            r_m_req       <= 1'b0;
            r_m_we        <= 1'b0;
            r_m_addr      <= '0;
            r_m_wdata     <= '0;
            r_m_burst_len <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_ready && w_sel_valid) begin
                        r_grant       <= w_sel_grant;
                        r_m_req       <= 1'b1;
                        r_m_we        <= p_we[w_sel_grant];
                        r_m_addr      <= p_addr[int'(w_sel_grant)*ADDR_W +: ADDR_W];
                        r_m_wdata     <= p_wdata[int'(w_sel_grant)*WDATA_W +: WDATA_W];
                        r_m_burst_len <= p_burst_len[int'(w_sel_grant)*BURST_LEN_W +: BURST_LEN_W];
                        r_state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (m_ack) begin
                        r_m_req       <= 1'b0;
                        r_m_burst_len <= '0;
                        // The display port sits outside the rotation and leaves the pointer alone.
                        if (r_grant != '0) begin
                            r_rr_ptr <= (int'(r_grant) == NUM_PORTS - 1) ? IW'(1) : r_grant + IW'(1);
                        end
                        r_rel_mask    <= w_grant_onehot;
                        r_state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_rel_mask <= '0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_grant_onehot = NUM_PORTS'(1) << r_grant;
    assign w_active       = (r_state == ACTIVE);
    assign w_ack_fire     = w_active && m_ack;
    assign w_beat_fire    = w_active && m_burst_valid;

    // Responses are combinational so the controller's ack and beats reach the owner with no added latency.
    assign p_ack         = w_ack_fire  ? w_grant_onehot : '0;
    assign p_rdata       = w_ack_fire  ? m_rdata        : '0;
    assign p_burst_valid = w_beat_fire ? w_grant_onehot : '0;
    assign p_burst_rdata = m_burst_rdata;
    assign p_ready       = {NUM_PORTS{(r_state == IDLE) && m_ready}};

    assign m_req       = r_m_req;
    assign m_we        = r_m_we;
    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;
    assign m_burst_len = r_m_burst_len;

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// tb/tb_sram_burst_arbiter.sv - self-checking bench for sram_burst_arbiter

module tb_sram_burst_arbiter;
    import sram_arb_pkg::*;

    logic           clk_sram;
    logic           rst_n_sram;
    logic [3:0]     p_req;
    logic [3:0]     p_we;
    logic [95:0]    p_addr;
    logic [127:0]   p_wdata;
    logic [31:0]    p_burst_len;
    logic [3:0]     p_ack;
    logic [3:0]     p_ready;
    logic [31:0]    p_rdata;
    logic [15:0]    p_burst_rdata;
    logic [3:0]     p_burst_valid;
    logic           m_req;
    logic           m_we;
    logic [23:0]    m_addr;
    logic [31:0]    m_wdata;
    logic [7:0]     m_burst_len;
    logic [31:0]    m_rdata;
    logic [15:0]    m_burst_rdata;
    logic           m_burst_valid;
    logic           m_ack;
    logic           m_ready;

    sram_burst_arbiter #(
        .NUM_PORTS (4),
        .ADDR_W    (24)
    ) dut (
        .clk_sram      (clk_sram),
        .rst_n_sram    (rst_n_sram),
        .p_req         (p_req),
        .p_we          (p_we),
        .p_addr        (p_addr),
        .p_wdata       (p_wdata),
        .p_burst_len   (p_burst_len),
        .p_ack         (p_ack),
        .p_ready       (p_ready),
        .p_rdata       (p_rdata),
        .p_burst_rdata (p_burst_rdata),
        .p_burst_valid (p_burst_valid),
        .m_req         (m_req),
        .m_we          (m_we),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_burst_len   (m_burst_len),
        .m_rdata       (m_rdata),
        .m_burst_rdata (m_burst_rdata),
        .m_burst_valid (m_burst_valid),
        .m_ack         (m_ack),
        .m_ready       (m_ready)
    );

    initial clk_sram = 1'b0;
    always #5 clk_sram = ~clk_sram;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       ack;
        logic       exp_mreq;
        int         exp_port;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t vt[10];
    int   rr_exp[4] = '{1, 2, 3, 1};

    // reference model state
    int          mo;
    int          mnext;
    int          win;
    int          cand;
    bit          mcool;
    bit          idle_now;
    logic        e_mreq;
    logic        e_mwe;
    logic [23:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [7:0]  e_mblen;
    logic [3:0]  e_ready;
    logic [3:0]  e_ack;
    logic [3:0]  e_bv;
    logic [31:0] e_rdata;

    // scratch
    int          beats;
    int          cnt0;
    int          acks;
    int          dbad;
    int          hbad;
    int          nloop;
    logic [2:0]  oth;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] addr_of(input int i);
        return 24'(i + 1) << 20;
    endfunction

    function automatic int port_of(input logic [23:0] a);
        return int'(a[23:20]) - 1;
    endfunction

    task automatic set_port(input int i, input logic we, input logic [23:0] a,
                            input logic [31:0] d, input logic [7:0] bl);
        p_we[i]              = we;
        p_addr[i*24 +: 24]   = a;
        p_wdata[i*32 +: 32]  = d;
        p_burst_len[i*8 +: 8] = bl;
    endtask

    task automatic default_ports();
        for (int i = 0; i < 4; i++) set_port(i, 1'b0, addr_of(i), 32'hA000_0000 + 32'(i), 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_sram);
        rst_n_sram    = 1'b0;
        p_req         = 4'b0;
        m_ack         = 1'b0;
        m_burst_valid = 1'b0;
        m_ready       = 1'b1;
        m_rdata       = 32'h0;
        m_burst_rdata = 16'h0;
        default_ports();
        repeat (2) @(negedge clk_sram);
        rst_n_sram = 1'b1;
    endtask

    task automatic wait_mreq(input string tag);
        int n;
        n = 0;
        while (m_req !== 1'b1 && n < 20) begin
            @(negedge clk_sram);
            #1;
            n++;
        end
        if (m_req !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: m_req=%b required 1", tag, m_req);
        end
    endtask

    task automatic ack_and_drop(input string tag, input logic [3:0] exp_ack);
        @(negedge clk_sram);
        m_ack = 1'b1;
        #1;
        chk({tag, "_ack"}, 64'(p_ack), 64'(exp_ack));
        @(negedge clk_sram);
        m_ack = 1'b0;
        p_req = p_req & ~exp_ack;
        repeat (2) @(negedge clk_sram);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'b0000, 1'b1, 1'b0, 1'b0, -1, 4'hF};
        vt[1] = '{4'b0001, 1'b1, 1'b0, 1'b1,  0, 4'hF};
        vt[2] = '{4'b0101, 1'b1, 1'b0, 1'b1,  0, 4'hF};
        vt[3] = '{4'b1110, 1'b1, 1'b0, 1'b1,  1, 4'hF};
        vt[4] = '{4'b1100, 1'b1, 1'b0, 1'b1,  2, 4'hF};
        vt[5] = '{4'b1000, 1'b1, 1'b1, 1'b1,  3, 4'hF};
        vt[6] = '{4'b0110, 1'b0, 1'b0, 1'b0, -1, 4'h0};
        vt[7] = '{4'b1111, 1'b1, 1'b1, 1'b1,  0, 4'hF};
        vt[8] = '{4'b1010, 1'b0, 1'b1, 1'b0, -1, 4'h0};
        vt[9] = '{4'b0100, 1'b1, 1'b0, 1'b1,  2, 4'hF};

        rst_n_sram    = 1'b1;
        p_req         = 4'b0;
        p_we          = 4'b0;
        p_addr        = '0;
        p_wdata       = '0;
        p_burst_len   = '0;
        m_rdata       = 32'h0;
        m_burst_rdata = 16'h0;
        m_burst_valid = 1'b0;
        m_ack         = 1'b0;
        m_ready       = 1'b1;

        // reset values, with controller inputs deliberately active
        @(negedge clk_sram);
        rst_n_sram    = 1'b0;
        m_ack         = 1'b1;
        m_burst_valid = 1'b1;
        m_rdata       = 32'hFFFF_FFFF;
        #1;
        chk("reset_m_ctl", 64'({m_req, m_we, m_burst_len, m_addr}), 64'(0));
        chk("reset_m_wdata", 64'(m_wdata), 64'(0));
        chk("reset_p_ack", 64'(p_ack), 64'(0));
        chk("reset_p_bv", 64'(p_burst_valid), 64'(0));
        chk("reset_p_rdata", 64'(p_rdata), 64'(0));
        chk("reset_p_ready_hi", 64'(p_ready), 64'(4'hF));
        @(negedge clk_sram);
        m_ready = 1'b0;
        #1;
        chk("reset_p_ready_lo", 64'(p_ready), 64'(0));

        // table-driven first arbitration after reset (rr_ptr = 1)
        for (int v = 0; v < 10; v++) begin
            do_reset();
            @(negedge clk_sram);
            p_req   = vt[v].req;
            m_ready = vt[v].rdy;
            m_ack   = vt[v].ack;
            #1;
            chk($sformatf("tab%0d_ready", v), 64'(p_ready), 64'(vt[v].exp_ready));
            chk($sformatf("tab%0d_idle_ack", v), 64'(p_ack), 64'(0));
            @(negedge clk_sram);
            m_ack = 1'b0;
            #1;
            chk($sformatf("tab%0d_mreq", v), 64'(m_req), 64'(vt[v].exp_mreq));
            chk($sformatf("tab%0d_addr", v), 64'(m_addr),
                64'((vt[v].exp_port < 0) ? 24'h0 : addr_of(vt[v].exp_port)));
        end

        // display priority and turnaround
        do_reset();
        @(negedge clk_sram);
        p_req = 4'b0001 | (4'b0001 << PORT_TEXTURE);
        #1;
        chk("dp_ready", 64'(p_ready), 64'(4'hF));
        @(negedge clk_sram);
        #1;
        chk("dp_first", 64'({m_req, m_addr}), 64'({1'b1, addr_of(PORT_DISPLAY)}));
        @(negedge clk_sram);
        m_ack   = 1'b1;
        m_rdata = 32'h1357_2468;
        #1;
        chk("dp_ack0", 64'(p_ack), 64'(4'b0001));
        chk("dp_rdata", 64'(p_rdata), 64'(32'h1357_2468));
        @(negedge clk_sram);
        m_ack = 1'b0;
        p_req = 4'b0100;
        #1;
        chk("dp_gap1", 64'({m_req, p_ready}), 64'(0));
        @(negedge clk_sram);
        #1;
        chk("dp_gap2", 64'({m_req, p_ready}), 64'({1'b0, 4'hF}));
        @(negedge clk_sram);
        #1;
        chk("dp_second", 64'({m_req, m_addr}), 64'({1'b1, addr_of(PORT_TEXTURE)}));
        ack_and_drop("dp2", 4'b0100);

        // round-robin among 1..3 with continuous requests
        do_reset();
        @(negedge clk_sram);
        p_req = 4'b1110;
        #1;
        for (int g = 0; g < 4; g++) begin
            wait_mreq($sformatf("rr%0d", g));
            chk($sformatf("rr%0d_port", g), 64'(port_of(m_addr)), 64'(rr_exp[g]));
            @(negedge clk_sram);
            m_ack = 1'b1;
            #1;
            chk($sformatf("rr%0d_ack", g), 64'(p_ack), 64'(4'b0001 << rr_exp[g]));
            @(negedge clk_sram);
            m_ack = 1'b0;
            #1;
            chk($sformatf("rr%0d_release", g), 64'(m_req), 64'(0));
            @(negedge clk_sram);
            #1;
            chk($sformatf("rr%0d_idle", g), 64'(m_req), 64'(0));
        end
        @(negedge clk_sram);
        p_req = 4'b0;

        // burst routing to the display port
        do_reset();
        set_port(PORT_DISPLAY, 1'b0, 24'h012C00, 32'h0, 8'd128);
        @(negedge clk_sram);
        p_req = 4'b0001;
        #1;
        wait_mreq("burst");
        chk("burst_fields", 64'({m_we, m_burst_len, m_addr}), 64'({1'b0, 8'd128, 24'h012C00}));
        beats = 0; cnt0 = 0; oth = 3'b0; dbad = 0; nloop = 0;
        while (beats < 128 && nloop < 1000) begin
            @(negedge clk_sram);
            nloop++;
            m_burst_valid = ($urandom % 4) != 0;
            m_burst_rdata = 16'($urandom);
            #1;
            if (m_burst_valid) beats++;
            if (p_burst_valid[0]) cnt0++;
            oth = oth | p_burst_valid[3:1];
            if (p_burst_valid[0] && p_burst_rdata !== m_burst_rdata) dbad++;
        end
        acks = 0;
        @(negedge clk_sram);
        m_burst_valid = 1'b0;
        m_ack = 1'b1;
        #1;
        if (p_ack[0]) acks++;
        @(negedge clk_sram);
        m_ack = 1'b0;
        p_req = 4'b0;
        #1;
        if (p_ack[0]) acks++;
        chk("burst_len_cleared", 64'({m_req, m_burst_len}), 64'(0));
        @(negedge clk_sram);
        #1;
        if (p_ack[0]) acks++;
        chk("burst_beats0", 64'(cnt0), 64'(128));
        chk("burst_other_strobes", 64'(oth), 64'(0));
        chk("burst_data", 64'(dbad), 64'(0));
        chk("burst_ack_once", 64'(acks), 64'(1));

        // single write from the SPI bridge, fields held while active
        set_port(PORT_SPI, 1'b1, 24'h000010, 32'hDEAD_BEEF, 8'd0);
        @(negedge clk_sram);
        p_req = 4'b1000;
        #1;
        wait_mreq("wr");
        chk("wr_ctl", 64'({m_we, m_burst_len, m_addr}), 64'({1'b1, 8'd0, 24'h000010}));
        chk("wr_data", 64'(m_wdata), 64'(32'hDEAD_BEEF));
        set_port(PORT_SPI, 1'b0, 24'hFFFFFF, 32'h0, 8'd5);
        hbad = 0;
        repeat (3) begin
            @(negedge clk_sram);
            #1;
            if ({m_req, m_we, m_burst_len, m_addr, m_wdata} !== {1'b1, 1'b1, 8'd0, 24'h000010, 32'hDEAD_BEEF})
                hbad++;
        end
        chk("wr_hold", 64'(hbad), 64'(0));
        ack_and_drop("wr", 4'b1000);
        default_ports();

        // flow control
        @(negedge clk_sram);
        m_ready = 1'b0;
        p_req   = 4'b0001 << PORT_PIXEL_WR;
        #1;
        hbad = 0;
        repeat (3) begin
            @(negedge clk_sram);
            #1;
            if (m_req !== 1'b0 || p_ready !== 4'h0) hbad++;
        end
        chk("fc_stalled", 64'(hbad), 64'(0));
        @(negedge clk_sram);
        m_ready = 1'b1;
        #1;
        chk("fc_ready", 64'({m_req, p_ready}), 64'({1'b0, 4'hF}));
        @(negedge clk_sram);
        #1;
        chk("fc_grant", 64'({m_req, m_addr}), 64'({1'b1, addr_of(PORT_PIXEL_WR)}));
        ack_and_drop("fc", 4'b0010);

        // reset in the middle of a burst
        do_reset();
        @(negedge clk_sram);
        p_req = 4'b0010;
        #1;
        wait_mreq("rb_pre");
        ack_and_drop("rb_pre", 4'b0010);
        set_port(PORT_TEXTURE, 1'b0, addr_of(PORT_TEXTURE), 32'h0, 8'd100);
        @(negedge clk_sram);
        p_req = 4'b0100;
        #1;
        wait_mreq("rb_burst");
        chk("rb_port", 64'(port_of(m_addr)), 64'(PORT_TEXTURE));
        cnt0 = 0;
        repeat (39) begin
            @(negedge clk_sram);
            m_burst_valid = 1'b1;
            #1;
            if (p_burst_valid[2]) cnt0++;
        end
        chk("rb_beats_before", 64'(cnt0), 64'(39));
        @(negedge clk_sram);
        rst_n_sram = 1'b0;
        #1;
        chk("rb_async_clear", 64'({m_req, m_burst_len, p_burst_valid}), 64'(0));
        hbad = 0;
        repeat (3) begin
            @(negedge clk_sram);
            #1;
            if (p_burst_valid !== 4'h0 || m_req !== 1'b0) hbad++;
        end
        @(negedge clk_sram);
        rst_n_sram = 1'b1;
        p_req = 4'b0;
        default_ports();
        repeat (2) begin
            @(negedge clk_sram);
            #1;
            if (p_burst_valid !== 4'h0 || m_req !== 1'b0) hbad++;
        end
        chk("rb_no_strobes", 64'(hbad), 64'(0));
        @(negedge clk_sram);
        m_burst_valid = 1'b0;
        p_req = 4'b1110;
        #1;
        wait_mreq("rb_after");
        chk("rb_rr_restart", 64'(port_of(m_addr)), 64'(1));
        ack_and_drop("rb_after", 4'b0010);

        // randomized traffic against a transaction-level model
        do_reset();
        mo = -1; mnext = 1; mcool = 1'b0;
        e_mreq = 1'b0; e_mwe = 1'b0; e_maddr = 24'h0; e_mwdata = 32'h0; e_mblen = 8'h0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_sram);
            p_req = 4'($urandom);
            for (int i = 0; i < 4; i++)
                set_port(i, 1'($urandom), 24'($urandom), $urandom,
                         (($urandom % 3) == 0) ? 8'($urandom) : 8'd0);
            m_ready       = ($urandom % 4) != 0;
            m_ack         = ($urandom % 4) == 0;
            m_burst_valid = 1'($urandom);
            m_rdata       = $urandom;
            m_burst_rdata = 16'($urandom);
            #1;
            idle_now = (mo < 0) && !mcool;
            e_ready  = (idle_now && m_ready) ? 4'hF : 4'h0;
            e_ack    = (mo >= 0 && m_ack) ? 4'(1 << mo) : 4'h0;
            e_rdata  = (mo >= 0 && m_ack) ? m_rdata : 32'h0;
            e_bv     = (mo >= 0 && m_burst_valid) ? 4'(1 << mo) : 4'h0;
            chk("rand_m_ctl", 64'({m_req, m_we, m_burst_len, m_addr}),
                64'({e_mreq, e_mwe, e_mblen, e_maddr}));
            chk("rand_m_wdata", 64'(m_wdata), 64'(e_mwdata));
            chk("rand_p_side", 64'({p_ack, p_burst_valid, p_ready}), 64'({e_ack, e_bv, e_ready}));
            chk("rand_rdata", 64'(p_rdata), 64'(e_rdata));
            // advance the model to the next cycle
            if (mo >= 0) begin
                if (m_ack) begin
                    e_mreq  = 1'b0;
                    e_mblen = 8'h0;
                    if (mo >= 1) mnext = (mo == 3) ? 1 : mo + 1;
                    mo    = -1;
                    mcool = 1'b1;
                end
            end else if (mcool) begin
                mcool = 1'b0;
            end else if (m_ready && p_req != 4'b0) begin
                win = -1;
                if (p_req[0]) win = 0;
                else begin
                    for (int j = 0; j < 3; j++) begin
                        cand = 1 + (mnext - 1 + j) % 3;
                        if (win < 0 && p_req[cand]) win = cand;
                    end
                end
                mo       = win;
                e_mreq   = 1'b1;
                e_mwe    = p_we[win];
                e_maddr  = p_addr[win*24 +: 24];
                e_mwdata = p_wdata[win*32 +: 32];
                e_mblen  = p_burst_len[win*8 +: 8];
            end
        end
        @(negedge clk_sram);
        p_req = 4'b0;
        m_ack = 1'b0;
        m_burst_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
